// File: rtl/fir_mac_param.sv
// fir_mac_param: serial-MAC direct-form FIR with a run-time writable coefficient file.
// One tap is accumulated per clock; the result is presented with a one-cycle y_valid pulse.
// Optional macro FIR_SYM_EN: symmetric-coefficient folding (pre-adds mirrored samples,
// stores and iterates over ceil(TAPS/2) coefficients only).
module fir_mac_param #(
  parameter int unsigned TAPS   = 31,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned ACC_W  = 23,
  parameter int unsigned AW     = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [ACC_W-1:0]  y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned IW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW     = IW + 1;
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
`ifdef FIR_SYM_EN
  localparam int unsigned MAC_N  = (TAPS + 1) / 2;
  localparam int unsigned CENTRE = (TAPS - 1) / 2;
`else
  localparam int unsigned MAC_N  = TAPS;
`endif

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     ready_prev_q;
  logic signed [DATA_W-1:0] samp_q [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];

  logic                     start_c;
  logic                     samp_we_c;
  logic                     coef_wr_c;
  logic [PW-1:0]            ptr_inc_c;
  logic [PW-1:0]            rd_a_c;
  logic signed [PRE_W-1:0]  pre_c;
  logic signed [PROD_W-1:0] prod_c;

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

  // Circular-buffer addressing: next write slot and the newest-relative tap read this cycle
  always_comb begin
    ptr_inc_c = PW'(wr_ptr_q) + PW'(1);
    if (ptr_inc_c == PW'(TAPS)) ptr_inc_c = '0;
    rd_a_c = PW'(wr_ptr_q) + PW'(TAPS) - PW'(idx_q);
    if (rd_a_c >= PW'(TAPS)) rd_a_c = rd_a_c - PW'(TAPS);
  end

`ifdef FIR_SYM_EN
  logic [PW-1:0]            rd_b_c;
  logic signed [DATA_W-1:0] samp_b_c;

  // Pre-add the mirrored sample pair; the centre tap of an odd filter stands alone
  always_comb begin
    rd_b_c = PW'(wr_ptr_q) + PW'(1) + PW'(idx_q);
    if (rd_b_c >= PW'(TAPS)) rd_b_c = rd_b_c - PW'(TAPS);
    samp_b_c = samp_q[IW'(rd_b_c)];
    if ((TAPS % 2 == 1) && (idx_q == IW'(CENTRE))) samp_b_c = '0;
    pre_c = PRE_W'(samp_q[IW'(rd_a_c)]) + PRE_W'(samp_b_c);
  end
`else
  // Single sample per tap, widened to the common pre-add width
  always_comb pre_c = PRE_W'(samp_q[IW'(rd_a_c)]);
`endif

  // Fully signed tap product
  always_comb prod_c = PROD_W'(pre_c) * PROD_W'(coef_q[idx_q]);

  // Next-state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = 1'b0;
    samp_we_c = 1'b0;
    start_c   = ready & ~ready_prev_q;
    coef_wr_c = coef_we && (state_q == IDLE) && (32'(coef_addr) < MAC_N);
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          wr_ptr_d  = IW'(ptr_inc_c);
          samp_we_c = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_d     = acc_q + ACC_W'(prod_c);
        idx_d     = idx_q + IW'(1);
        overrun_d = start_c;
        if (idx_q == IW'(MAC_N - 1)) state_d = DONE;
      end
      DONE: begin
        y_d       = acc_q;
        y_valid_d = 1'b1;
        overrun_d = start_c;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath, sample buffer and coefficient file registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      ready_prev_q <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        samp_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      ready_prev_q <= ready;
      if (samp_we_c) samp_q[wr_ptr_d] <= x;
      if (coef_wr_c) coef_q[IW'(coef_addr)] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// Self-checking bench for fir_mac_param: a sample-history/countdown reference model compared
// every cycle, plus directed vectors with hand-computed results. Honours FIR_SYM_EN.
module tb_fir_mac_param;

  localparam int TAPS   = 31;
  localparam int DATA_W = 8;
  localparam int COEF_W = 10;
  localparam int ACC_W  = 23;
  localparam int AW     = 6;
`ifdef FIR_SYM_EN
  localparam int NCOEF  = (TAPS + 1) / 2;
`else
  localparam int NCOEF  = TAPS;
`endif
  localparam int LAT    = NCOEF + 1;

  logic                     clock;
  logic                     reset;
  logic                     ready;
  logic signed [DATA_W-1:0] x;
  logic                     coef_we;
  logic        [AW-1:0]     coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic signed [ACC_W-1:0]  y;
  logic                     y_valid;
  logic                     busy;
  logic                     overrun;

  int checks   = 0;
  int failures = 0;

  fir_mac_param #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .AW(AW)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .y(y), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: newest-first sample history, coefficient list, result countdown
  int     m_hist [TAPS];
  int     m_coef [TAPS];
  int     m_cnt;
  longint m_y, m_pend;
  bit     m_valid, m_busy, m_ovr, m_prev, m_live, m_st;

  initial m_live = 1'b0;

  function automatic longint fir_sum();
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      int c;
`ifdef FIR_SYM_EN
      c = m_coef[(k < TAPS - 1 - k) ? k : TAPS - 1 - k];
`else
      c = m_coef[k];
`endif
      s += longint'(m_hist[k]) * longint'(c);
    end
    return s;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        m_hist[k] = 0;
        m_coef[k] = 0;
      end
      m_cnt = 0; m_y = 0; m_pend = 0;
      m_valid = 0; m_busy = 0; m_ovr = 0; m_prev = 0; m_live = 1;
    end else begin
      m_st    = ready && !m_prev;
      m_prev  = ready;
      m_valid = 0;
      m_ovr   = 0;
      if (m_cnt > 0) begin
        if (m_st) m_ovr = 1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_y     = m_pend;
          m_valid = 1;
        end
      end else begin
        if (coef_we && int'(coef_addr) < NCOEF) m_coef[coef_addr] = int'(coef_wdata);
        if (m_st) begin
          for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
          m_hist[0] = int'(x);
          m_pend    = fir_sum();
          m_cnt     = LAT;
        end
      end
      m_busy = (m_cnt > 0);
    end
  end

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (m_live) begin
      chk("cyc_y", y, m_y);
      chk("cyc_y_valid", y_valid, 64'(m_valid));
      chk("cyc_busy", busy, 64'(m_busy));
      chk("cyc_overrun", overrun, 64'(m_ovr));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; ready = 1'b0; coef_we = 1'b0; x = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wr(input int a, input int v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = COEF_W'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic strobe(input int v);
    ready = 1'b1; x = DATA_W'(v);
    tick();
    ready = 1'b0; x = '0;
  endtask

  task automatic wait_valid(output logic signed [63:0] yv, output int lat);
    bit got;
    got = 0; yv = '0; lat = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      tick();
      if (y_valid === 1'b1) begin
        got = 1; yv = y; lat = i;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL y_valid_timeout got=none exp=pulse at %0t", $time);
    end
  endtask

  task automatic run(input string nm, input int v, input longint e);
    logic signed [63:0] yv;
    int lat;
    strobe(v);
    wait_valid(yv, lat);
    chk({nm, "_y"}, yv, e);
    chk({nm, "_lat"}, lat, LAT);
  endtask

  initial begin
    logic signed [63:0] yv;
    int lat, nv;
    reset = 1'b1; ready = 1'b0; x = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    do_reset();
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
`ifndef FIR_SYM_EN
    // Passthrough
    wr(0, 1);
    run("pass_p5", 5, 5);
    repeat (40) tick();
    run("pass_m3", -3, -3);
    tick();
    chk("pulse_width", y_valid, 0);
    // Impulse response with pointer wrap
    do_reset();
    for (int k = 0; k < TAPS; k++) wr(k, k + 1);
    run("imp0", 1, 1);
    for (int j = 1; j <= 32; j++) run("imp", 0, (j < TAPS) ? j + 1 : 0);
    // Extreme values, back-to-back at minimum spacing
    do_reset();
    for (int k = 0; k < TAPS; k++) wr(k, -512);
    for (int j = 1; j <= TAPS; j++) run("ext", -128, longint'(j) * 65536);
    chk("ext_final", y, 2031616);
    // Overrun: second edge 10 clocks after the first
    do_reset();
    wr(0, 1); wr(1, 10);
    strobe(7);
    repeat (9) tick();
    strobe(9);
    chk("ovr_pulse", overrun, 1);
    wait_valid(yv, lat);
    chk("ovr_y", yv, 7);
    run("ovr_drop", 0, 70);
    // Reset mid-MAC
    do_reset();
    wr(0, 1);
    strobe(4);
    repeat (14) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rmac_busy", busy, 0);
    chk("rmac_y", y, 0);
    nv = 0;
    repeat (40) begin tick(); if (y_valid === 1'b1) nv++; end
    chk("rmac_novalid", nv, 0);
    wr(0, 1);
    run("rmac_after", 6, 6);
    // Coefficient write rules
    do_reset();
    wr(0, 1); wr(31, 100);
    run("addr31", 3, 3);
    strobe(2);
    repeat (5) tick();
    wr(0, 50);
    wait_valid(yv, lat);
    chk("busy_wr_y", yv, 2);
    run("busy_wr_next", 1, 1);
    coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(3); ready = 1'b1; x = DATA_W'(2);
    tick();
    coef_we = 1'b0; ready = 1'b0; x = '0;
    wait_valid(yv, lat);
    chk("same_edge_y", yv, 6);
    // ready held high: exactly one computation
    ready = 1'b1; x = DATA_W'(4); nv = 0;
    repeat (80) begin tick(); if (y_valid === 1'b1) nv++; end
    ready = 1'b0; x = '0;
    chk("held_high_count", nv, 1);
    chk("held_high_y", y, 12);
`else
    // Symmetric impulse: 31 outputs of 2, then 0
    for (int k = 0; k < 16; k++) wr(k, 1);
    wr(16, 5);
    run("sym0", 2, 2);
    for (int j = 1; j < TAPS; j++) run("sym", 0, 2);
    run("sym_end", 0, 0);
    // Overrun and reset-mid-MAC in the folded build
    strobe(3);
    repeat (5) tick();
    strobe(8);
    chk("sym_ovr_pulse", overrun, 1);
    wait_valid(yv, lat);
    chk("sym_ovr_y", yv, 3);
    strobe(4);
    repeat (8) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("sym_rmac_busy", busy, 0);
    nv = 0;
    repeat (25) begin tick(); if (y_valid === 1'b1) nv++; end
    chk("sym_rmac_novalid", nv, 0);
`endif
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
